dac_write_scheduler: RTL and testbench
======================================

DAC_WRITE_SCHEDULER -- requirements
Module: dac_write_scheduler

Interface
REQ-001 Parameter CMD_WRITE, 4'h3, command nibble for drive-current write words.
REQ-002 Parameter CMD_LIMIT, 4'h8, command nibble for current-limit write words.
REQ-003 Parameter RESET_CURRENT, 16'h3600, drive-current register value after reset.
REQ-004 Parameter RESET_LIMIT, 16'h3F00, current-limit register value after reset.
REQ-005 Parameter GAP_CYCLES, 4, minimum idle clk cycles between an accepted word and the next spi_valid.
REQ-006 clk  in  1  25 MHz system clock; single clock domain.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 shutdown  in  1  level; OR of TA electrical and optical shutdowns.
REQ-009 pulse_start  in  1  single-cycle strobe; laser pulse begins.
REQ-010 pulse_end  in  1  single-cycle strobe; laser pulse ends.
REQ-011 cfg_update  in  1  single-cycle strobe; latch drive_current and drive_current_limit.
REQ-012 drive_current  in  16  requested drive-current DAC code.
REQ-013 drive_current_limit  in  16  requested current-limit DAC code.
REQ-014 spi_word  out  24  {cmd[3:0], data[15:0], 4'h0}, MSB first to the SPI engine.
REQ-015 spi_valid  out  1  spi_word is valid; held until accepted.
REQ-016 spi_ready  in  1  SPI engine idle; a word is accepted on any cycle with spi_valid and spi_ready both high.
REQ-017 laser_on  out  1  a nonzero drive-current word is in effect.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 drop_count  out  8  saturating count of discarded pulse_start requests.

Function
REQ-020 Pending flags: pend_zero (zero-current word), pend_on (drive-current word), pend_cfg (limit word); each flag is set on the clk edge that samples its trigger.
REQ-021 pulse_start sets pend_on and snapshots drive_current_reg into on_data; a pulse_start while pend_on is already set increments drop_count and leaves on_data unchanged.
REQ-022 pulse_end sets pend_zero; if pend_on is set at that edge, pend_on is cleared and drop_count increments.
REQ-023 pulse_start and pulse_end in the same cycle are handled as pulse_end, and the start is counted as dropped.
REQ-024 cfg_update loads drive_current_reg and limit_reg and sets pend_cfg; the new current value applies from the next pulse_start.
REQ-025 Rising edge of shutdown sets pend_zero and clears laser_on on the next edge; while shutdown is high, pulse_start is ignored and counted as dropped, and pend_on is forced clear.
REQ-026 Priority when leaving IDLE is pend_zero, then pend_on, then pend_cfg; pend_cfg waits behind the others without loss.
REQ-027 States are IDLE, ISSUE, GAP. IDLE->ISSUE when any flag is set; ISSUE->GAP on accept; GAP->IDLE after GAP_CYCLES cycles.
REQ-028 On entry to ISSUE, spi_word and spi_valid are registered, and the selected pending flag clears.
REQ-029 Latency: a request strobe in cycle N, with the scheduler in IDLE, gives spi_valid high in cycle N+2.
REQ-030 spi_word stays stable while spi_valid is high and not accepted; shutdown does not withdraw a presented word, and the zero word follows it.
REQ-031 Word encodings: zero = {CMD_WRITE,16'h0,4'h0}; on = {CMD_WRITE,on_data,4'h0}; limit = {CMD_LIMIT,limit_reg,4'h0}.
REQ-032 laser_on is set on accept of an on-word whose data is nonzero, and cleared on accept of a zero word or per REQ-025.
REQ-033 drop_count holds at 8'hFF once it reaches that value.

Reset
REQ-034 While rst is high, the following reset values apply: state=IDLE, all pending flags 0, spi_valid=0, spi_word=0, laser_on=0, busy=0, drop_count=0, drive_current_reg=RESET_CURRENT, limit_reg=RESET_LIMIT, on_data=0.
REQ-035 rst asserted mid-transfer drops the presented word immediately; no pending flag survives reset.

Structure
REQ-036 CMD_WRITE, CMD_LIMIT, the state encoding and the word-format field widths belong in shared package ta_dac_pkg.
REQ-037 One sub-module, dac_word_fmt, is combinational and builds the 24-bit word from cmd and data; all sequencing stays in dac_write_scheduler.

Verification
REQ-038 Scenario: reset; pulse_start with spi_ready=1 -> spi_valid at N+2, spi_word=24'h336000, and laser_on=1 after accept.
REQ-039 Scenario: cfg_update with drive_current=16'h1234 and limit=16'h2000 -> word 24'h820000; next pulse -> word 24'h312340.
REQ-040 Scenario: pulse_start then pulse_end with spi_ready=0 -> one on-word presented and held stable; after ready, zero word 24'h300000 follows after GAP_CYCLES; laser_on ends 0.
REQ-041 Scenario: shutdown rises while laser_on=1 -> laser_on=0 next cycle; zero word issued; pulse_starts during shutdown -> drop_count +1 each and no on-words.
REQ-042 Scenario: pulse_start and pulse_end in the same cycle -> only a zero word is issued; drop_count=1.
REQ-043 Scenario: 300 pulse_starts with spi_ready=0 -> drop_count saturates at 8'hFF; rst mid-ISSUE -> spi_valid=0 next cycle.

Source files
------------

// File: rtl/ta_dac_pkg.sv
// Shared definitions for the TA DAC write path: command nibbles, word layout and scheduler state.
package ta_dac_pkg;

  localparam int CMD_W  = 4;
  localparam int DATA_W = 16;
  localparam int PAD_W  = 4;
  localparam int WORD_W = CMD_W + DATA_W + PAD_W;

  localparam logic [CMD_W-1:0] CMD_WRITE = 4'h3;
  localparam logic [CMD_W-1:0] CMD_LIMIT = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_GAP
  } state_e;

  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_ON,
    SEL_CFG
  } sel_e;

endpackage

// File: rtl/dac_word_fmt.sv
// Packs a DAC command nibble and 16-bit code into the 24-bit SPI word, MSB first.
module dac_word_fmt
  import ta_dac_pkg::*;
(
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] data,
  output logic [WORD_W-1:0] word
);

  assign word = {cmd, data, {PAD_W{1'b0}}};

endmodule

// File: rtl/dac_write_scheduler.sv
// Turns laser pulse strobes, shutdown and config updates into a paced stream of DAC write words.
module dac_write_scheduler #(
  parameter logic [3:0]  CMD_WRITE     = ta_dac_pkg::CMD_WRITE,
  parameter logic [3:0]  CMD_LIMIT     = ta_dac_pkg::CMD_LIMIT,
  parameter logic [15:0] RESET_CURRENT = 16'h3600,
  parameter logic [15:0] RESET_LIMIT   = 16'h3F00,
  parameter int          GAP_CYCLES    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          shutdown,
  input  logic                          pulse_start,
  input  logic                          pulse_end,
  input  logic                          cfg_update,
  input  logic [ta_dac_pkg::DATA_W-1:0] drive_current,
  input  logic [ta_dac_pkg::DATA_W-1:0] drive_current_limit,
  output logic [ta_dac_pkg::WORD_W-1:0] spi_word,
  output logic                          spi_valid,
  input  logic                          spi_ready,
  output logic                          laser_on,
  output logic                          busy,
  output logic [7:0]                    drop_count
);
  import ta_dac_pkg::*;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_e            state, state_n;
  sel_e              sel;
  logic              pend_zero, pend_on, pend_cfg;
  logic [DATA_W-1:0] drive_current_reg, limit_reg, on_data;
  logic              shutdown_q;
  logic [7:0]        gap_cnt;
  logic              cur_on_nz, cur_zero;
  logic [CMD_W-1:0]  sel_cmd;
  logic [DATA_W-1:0] sel_data;
  logic [WORD_W-1:0] sel_word;
  logic              any_pend, issue_now, accept, shut_rise, on_taken;
  logic              start_drop, start_take, end_kill;
  logic [8:0]        drop_sum;

  dac_word_fmt u_fmt (
    .cmd  (sel_cmd),
    .data (sel_data),
    .word (sel_word)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // An on-word leaving the pending set this edge frees the slot for a new start.
  always_comb begin
    state_n    = state;
    any_pend   = pend_zero | pend_on | pend_cfg;
    accept     = spi_valid & spi_ready;
    shut_rise  = shutdown & ~shutdown_q;
    sel        = SEL_CFG;
    sel_cmd    = CMD_LIMIT;
    sel_data   = limit_reg;
    if (pend_zero) begin
      sel      = SEL_ZERO;
      sel_cmd  = CMD_WRITE;
      sel_data = '0;
    end else if (pend_on) begin
      sel      = SEL_ON;
      sel_cmd  = CMD_WRITE;
      sel_data = on_data;
    end
    issue_now  = (state == ST_IDLE) & any_pend;
    on_taken   = issue_now & (sel == SEL_ON);
    start_drop = pulse_start & (pulse_end | shutdown | (pend_on & ~on_taken));
    start_take = pulse_start & ~start_drop;
    end_kill   = pulse_end & pend_on & ~on_taken;
    drop_sum   = {1'b0, drop_count} + 9'(start_drop) + 9'(end_kill);
    case (state)
      ST_IDLE:  if (any_pend) state_n = ST_ISSUE;
      ST_ISSUE: if (accept) state_n = ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_zero         <= 1'b0;
      pend_on           <= 1'b0;
      pend_cfg          <= 1'b0;
      spi_valid         <= 1'b0;
      spi_word          <= '0;
      laser_on          <= 1'b0;
      drop_count        <= '0;
      drive_current_reg <= RESET_CURRENT;
      limit_reg         <= RESET_LIMIT;
      on_data           <= '0;
      shutdown_q        <= 1'b0;
      gap_cnt           <= '0;
      cur_on_nz         <= 1'b0;
      cur_zero          <= 1'b0;
    end else begin
      shutdown_q <= shutdown;
      if (cfg_update) begin
        drive_current_reg <= drive_current;
        limit_reg         <= drive_current_limit;
      end
      if (start_take) on_data <= drive_current_reg;

      pend_zero <= (pend_zero & ~(issue_now & (sel == SEL_ZERO))) | pulse_end | shut_rise;
      pend_cfg  <= (pend_cfg & ~(issue_now & (sel == SEL_CFG))) | cfg_update;
      if (shutdown || pulse_end) pend_on <= 1'b0;
      else if (start_take)       pend_on <= 1'b1;
      else if (on_taken)         pend_on <= 1'b0;

      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];

      // The presented word is frozen until accepted; its kind decides laser_on at accept.
      if (issue_now) begin
        spi_word  <= sel_word;
        spi_valid <= 1'b1;
        cur_on_nz <= (sel == SEL_ON) && (on_data != '0);
        cur_zero  <= (sel == SEL_ZERO) || ((sel == SEL_ON) && (on_data == '0));
      end else if (accept) begin
        spi_valid <= 1'b0;
      end

      if (shut_rise)                          laser_on <= 1'b0;
      else if (accept && cur_zero)            laser_on <= 1'b0;
      else if (accept && cur_on_nz && !shutdown) laser_on <= 1'b1;

      if (state == ST_GAP) gap_cnt <= gap_cnt + 8'd1;
      else                 gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Scenario bench for dac_write_scheduler with a word scoreboard checked on every SPI accept.
module tb_dac_write_scheduler;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst, shutdown, pulse_start, pulse_end, cfg_update, spi_ready;
  logic [15:0] drive_current, drive_current_limit;
  logic [23:0] spi_word;
  logic        spi_valid, laser_on, busy;
  logic [7:0]  drop_count;

  int          vectors = 0;
  int          miscompares = 0;
  int          exp_drop = 0;
  logic [23:0] exp_q[$];
  logic [23:0] held_word;
  logic        held = 1'b0;

  always #20 clk = ~clk;

  dac_write_scheduler #(
    .CMD_WRITE(4'h3), .CMD_LIMIT(4'h8), .RESET_CURRENT(16'h3600),
    .RESET_LIMIT(16'h3F00), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst(rst), .shutdown(shutdown), .pulse_start(pulse_start),
    .pulse_end(pulse_end), .cfg_update(cfg_update), .drive_current(drive_current),
    .drive_current_limit(drive_current_limit), .spi_word(spi_word),
    .spi_valid(spi_valid), .spi_ready(spi_ready), .laser_on(laser_on),
    .busy(busy), .drop_count(drop_count)
  );

  // Scoreboard: every accepted word must match the oldest expected word; held words must not move.
  always @(negedge clk) begin
    logic [23:0] exp;
    if (rst) begin
      held = 1'b0;
    end else if (spi_valid) begin
      if (held) begin
        vectors++;
        if (spi_word !== held_word) begin
          miscompares++;
          $display("[TB] FAIL word_stable: got %h required %h", spi_word, held_word);
        end
      end
      if (spi_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_word: got %h required none", spi_word);
        end else begin
          exp = exp_q.pop_front();
          if (spi_word !== exp) begin
            miscompares++;
            $display("[TB] FAIL accepted_word: got %h required %h", spi_word, exp);
          end
        end
        held = 1'b0;
      end else begin
        held      = 1'b1;
        held_word = spi_word;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    exp_q.delete();
    exp_drop = 0;
    rst = 1'b0;
    step();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy || spi_valid) && n < 300) begin
      step();
      n++;
    end
    step();
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("[TB] FAIL idle_timeout: got busy=%b queue=%0d required idle", busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors += 5;
    if (spi_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b required 0", spi_valid); end
    if (spi_word !== 24'h0) begin miscompares++; $display("[TB] FAIL reset_word: got %h required 000000", spi_word); end
    if (laser_on !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_laser: got %b required 0", laser_on); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    if (drop_count !== 8'h0) begin miscompares++; $display("[TB] FAIL reset_drop: got %h required 00", drop_count); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_pulse_on();
    spi_ready = 1'b1;
    pulse_start = 1'b1;
    exp_q.push_back(24'h336000);
    step();
    pulse_start = 1'b0;
    vectors++;
    if (spi_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL latency_n1: got %b required 0", spi_valid); end
    step();
    vectors += 2;
    if (spi_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL latency_n2: got %b required 1", spi_valid); end
    if (spi_word !== 24'h336000) begin miscompares++; $display("[TB] FAIL on_word_reset: got %h required 336000", spi_word); end
    step();
    vectors++;
    if (laser_on !== 1'b1) begin miscompares++; $display("[TB] FAIL laser_after_on: got %b required 1", laser_on); end
    wait_idle();
  endtask

  task automatic test_cfg();
    drive_current = 16'h1234;
    drive_current_limit = 16'h2000;
    cfg_update = 1'b1;
    exp_q.push_back(24'h820000);
    step();
    cfg_update = 1'b0;
    wait_idle();
    pulse_start = 1'b1;
    exp_q.push_back(24'h312340);
    step();
    pulse_start = 1'b0;
    wait_idle();
    vectors++;
    if (laser_on !== 1'b1) begin miscompares++; $display("[TB] FAIL laser_after_cfg_on: got %b required 1", laser_on); end
  endtask

  task automatic test_hold();
    int idle = 0;
    spi_ready = 1'b0;
    pulse_start = 1'b1;
    exp_q.push_back(24'h312340);
    step();
    pulse_start = 1'b0;
    repeat (3) step();
    vectors += 2;
    if (spi_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_valid: got %b required 1", spi_valid); end
    if (spi_word !== 24'h312340) begin miscompares++; $display("[TB] FAIL hold_word: got %h required 312340", spi_word); end
    pulse_end = 1'b1;
    exp_q.push_back(24'h300000);
    step();
    pulse_end = 1'b0;
    repeat (3) step();
    vectors++;
    if (spi_word !== 24'h312340) begin miscompares++; $display("[TB] FAIL hold_word_late: got %h required 312340", spi_word); end
    spi_ready = 1'b1;
    step();
    while (!spi_valid && idle < 20) begin
      idle++;
      step();
    end
    vectors++;
    if (idle < GAP || idle > GAP + 1) begin
      miscompares++;
      $display("[TB] FAIL gap_cycles: got %0d required %0d..%0d", idle, GAP, GAP + 1);
    end
    wait_idle();
    vectors += 2;
    if (laser_on !== 1'b0) begin miscompares++; $display("[TB] FAIL laser_after_zero: got %b required 0", laser_on); end
    if (drop_count !== 8'(exp_drop)) begin miscompares++; $display("[TB] FAIL hold_drop: got %h required %h", drop_count, 8'(exp_drop)); end
  endtask

  task automatic test_shutdown();
    pulse_start = 1'b1;
    exp_q.push_back(24'h312340);
    step();
    pulse_start = 1'b0;
    wait_idle();
    vectors++;
    if (laser_on !== 1'b1) begin miscompares++; $display("[TB] FAIL laser_before_sd: got %b required 1", laser_on); end
    shutdown = 1'b1;
    exp_q.push_back(24'h300000);
    step();
    vectors++;
    if (laser_on !== 1'b0) begin miscompares++; $display("[TB] FAIL laser_sd_next: got %b required 0", laser_on); end
    for (int i = 0; i < 3; i++) begin
      pulse_start = 1'b1;
      step();
      pulse_start = 1'b0;
      step();
      exp_drop++;
    end
    wait_idle();
    vectors += 2;
    if (drop_count !== 8'(exp_drop)) begin miscompares++; $display("[TB] FAIL sd_drop: got %h required %h", drop_count, 8'(exp_drop)); end
    if (laser_on !== 1'b0) begin miscompares++; $display("[TB] FAIL laser_during_sd: got %b required 0", laser_on); end
    shutdown = 1'b0;
    step();
  endtask

  task automatic test_same_cycle();
    do_reset();
    spi_ready = 1'b1;
    pulse_start = 1'b1;
    pulse_end = 1'b1;
    exp_q.push_back(24'h300000);
    exp_drop++;
    step();
    pulse_start = 1'b0;
    pulse_end = 1'b0;
    wait_idle();
    vectors += 2;
    if (drop_count !== 8'(exp_drop)) begin miscompares++; $display("[TB] FAIL same_cycle_drop: got %h required %h", drop_count, 8'(exp_drop)); end
    if (laser_on !== 1'b0) begin miscompares++; $display("[TB] FAIL same_cycle_laser: got %b required 0", laser_on); end
  endtask

  task automatic test_back_to_back();
    logic seen = 1'b0;
    do_reset();
    spi_ready = 1'b0;
    exp_q.push_back(24'h336000);
    for (int i = 0; i < 300; i++) begin
      pulse_start = 1'b1;
      step();
    end
    pulse_start = 1'b0;
    step();
    vectors += 3;
    if (drop_count !== 8'hFF) begin miscompares++; $display("[TB] FAIL drop_saturate: got %h required ff", drop_count); end
    if (spi_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_valid: got %b required 1", spi_valid); end
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_busy: got %b required 1", busy); end
    rst = 1'b1;
    step();
    exp_q.delete();
    vectors += 2;
    if (spi_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_issue: got %b required 0", spi_valid); end
    if (drop_count !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_drop: got %h required 00", drop_count); end
    rst = 1'b0;
    spi_ready = 1'b1;
    repeat (10) begin
      step();
      if (spi_valid) seen = 1'b1;
    end
    vectors += 2;
    if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL pend_after_rst: got %b required 0", seen); end
    if (exp_q.size() != 0) begin miscompares++; $display("[TB] FAIL queue_left: got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1;
    shutdown = 1'b0;
    pulse_start = 1'b0;
    pulse_end = 1'b0;
    cfg_update = 1'b0;
    spi_ready = 1'b0;
    drive_current = 16'h0;
    drive_current_limit = 16'h0;
    test_reset();
    test_pulse_on();
    test_cfg();
    test_hold();
    test_shutdown();
    test_same_cycle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
